// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device model: FSM encodings, status word layout, command bit fields.
// Latency: n/a (package).  Backpressure: n/a.
package dma_pkg;

    typedef logic [1:0] dma_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_LSB  = 8;

    // Command-word bit that selects transfer direction (1 = memory-to-device).
    localparam int DIR_BIT = 9;

    function automatic logic [31:0] status_word(input logic [7:0] err,
                                                input logic       done,
                                                input logic       busy);
        logic [31:0] w;
        w                      = '0;
        w[STAT_BUSY_BIT]       = busy;
        w[STAT_DONE_BIT]       = done;
        w[STAT_ERR_LSB +: 8]   = err;
        return w;
    endfunction

endpackage

// File: rtl/dma_edge_det.sv
// Registers a strobe and flags its rising edge.
// Latency: pulse is combinational from sig against the one-cycle-old copy.  Backpressure: none.
module dma_edge_det (
    input  logic clk32,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk32) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/dma_dev_model.sv
// DMA peripheral model: command/status registers, BURST-word transfer driven by RDY_I edges; DIN checking under DMA_DEV_CHECK_EN.
// Latency: command -> XFER/RDY_O next cycle; word edge -> DOUT/counter next cycle; status on DOUT one cycle after read.
// Backpressure: RDY_O requests words while fewer than BURST accepted; register accesses drop a coincident RDY_I edge.
module dma_dev_model
    import dma_pkg::*;
#(
    parameter int          DW    = 16,
    parameter int          BURST = 16,
    parameter logic [31:0] SEED  = 32'h200
) (
    input  logic          clk32,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          FCS_N,
    input  logic          RW,
    input  logic          A1,
    input  logic          RDY_I,
    output logic          RDY_O,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic          busy,
    output logic [7:0]    err_cnt
);

    localparam logic [DW-1:0] SEED_W   = SEED[DW-1:0];
    localparam logic [7:0]    LAST_IDX = 8'(BURST - 1);

    dma_state_t    state;
    logic [7:0]    word_cnt;
    logic [7:0]    err_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] stat_q;
    logic          stat_sel;
    logic          dir_q;
    logic          rdy_o_q;
    logic          rdy_rise;
    logic          cmd_dir;
    logic          cmd_wr;
    logic          stat_rd;
    logic          accept;
    logic          last_word;

`ifdef DMA_DEV_CHECK_EN
    logic [DW-1:0] exp_q;
`else
    logic          unused_din;
    assign unused_din = ^DIN;
`endif

    dma_edge_det u_edge (
        .clk32 (clk32),
        .rst   (rst),
        .sig   (RDY_I),
        .rise  (rdy_rise)
    );

    // Narrow buses have no direction bit; such builds only run device-to-memory.
    generate
        if (DW > DIR_BIT) begin : g_dir
            assign cmd_dir = DIN[DIR_BIT];
        end else begin : g_nodir
            assign cmd_dir = 1'b0;
        end
    endgenerate

    assign cmd_wr    = ~FCS_N & ~RW &  A1;
    assign stat_rd   = ~FCS_N &  RW & ~A1;
    assign accept    = FCS_N & rdy_rise & (state == ST_XFER);
    assign last_word = (word_cnt == LAST_IDX);

    always_ff @(posedge clk32) begin
        if (rst) begin
            state    <= ST_IDLE;
            rdy_o_q  <= 1'b0;
            data_q   <= '0;
            stat_q   <= '0;
            stat_sel <= 1'b0;
            word_cnt <= '0;
            err_q    <= '0;
            dir_q    <= 1'b0;
`ifdef DMA_DEV_CHECK_EN
            exp_q    <= '0;
`endif
        end else if (cmd_wr) begin
            state    <= ST_XFER;
            rdy_o_q  <= 1'b1;
            data_q   <= SEED_W;
            stat_sel <= 1'b0;
            word_cnt <= '0;
            err_q    <= '0;
            dir_q    <= cmd_dir;
`ifdef DMA_DEV_CHECK_EN
            exp_q    <= SEED_W;
`endif
        end else if (stat_rd) begin
            // Status stays on DOUT until the next accepted word or command.
            stat_q   <= DW'(status_word(err_q, state == ST_DONE, state == ST_XFER));
            stat_sel <= 1'b1;
        end else if (accept) begin
            word_cnt <= word_cnt + 8'd1;
            stat_sel <= 1'b0;
            if (!dir_q) begin
                data_q <= data_q + DW'(1);
            end
`ifdef DMA_DEV_CHECK_EN
            if (dir_q) begin
                exp_q <= exp_q + DW'(1);
                if ((DIN != exp_q) && (err_q != 8'hFF)) begin
                    err_q <= err_q + 8'd1;
                end
            end
`endif
            if (last_word) begin
                state   <= ST_DONE;
                rdy_o_q <= 1'b0;
            end
        end else if ((state != ST_XFER) && clk_en) begin
            rdy_o_q <= 1'b0;
        end
    end

    assign RDY_O   = rdy_o_q;
    assign DOUT    = stat_sel ? stat_q : data_q;
    assign busy    = (state == ST_XFER);
    assign err_cnt = err_q;

endmodule

// File: doc/dma_dev_model.md
DMA_DEV_MODEL -- requirements
Module: dma_dev_model

Interface
- REQ-001 SHALL have parameter DW, default 16: data bus width in bits, with 8 <= DW <= 32.
- REQ-002 SHALL have parameter BURST, default 16: words per transfer, with 1 <= BURST <= 255.
- REQ-003 SHALL have parameter SEED, default 'h200: first data word of every transfer.
- REQ-004 Port clk32, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 Port clk_en, input, 1 bit: clock enable for idle-time RDY_O release.
- REQ-007 Port FCS_N, input, 1 bit: device chip select, active low.
- REQ-008 Port RW, input, 1 bit: 1 = host read, 0 = host write.
- REQ-009 Port A1, input, 1 bit: 0 = status/data register, 1 = command register.
- REQ-010 Port RDY_I, input, 1 bit: DMA acknowledge strobe from the controller.
- REQ-011 Port RDY_O, output, 1 bit: device data request.
- REQ-012 Port DIN, input, DW bits: data from the controller.
- REQ-013 Port DOUT, output, DW bits: data or status to the controller.
- REQ-014 Port busy, output, 1 bit: high while a transfer is active.
- REQ-015 Port err_cnt, output, 8 bits: count of mismatched words.

Function
- REQ-016 State machine: IDLE, XFER, DONE.
- REQ-017 Command write (FCS_N=0, RW=0, A1=1):
  - aborts any active transfer;
  - clears the word counter and err_cnt;
  - loads DOUT and the expected-value register with SEED;
  - latches dir = DIN[9] (0 = device-to-memory, 1 = memory-to-device);
  - sets RDY_O=1 and enters XFER on the next cycle.
- REQ-018 Status read (FCS_N=0, RW=1, A1=0): DOUT = {err_cnt, 6'b0, state==DONE, busy}, zero-extended or truncated to DW. Checked one cycle after the access.
- REQ-019 Any other FCS_N=0 access SHALL be ignored.
- REQ-020 rdy_d SHALL register RDY_I every cycle. A word is accepted on the cycle when RDY_I=1 and rdy_d=0 (rising edge).
- REQ-021 In XFER, RDY_O SHALL be 1 while words accepted < BURST.
- REQ-022 On each accepted word, dir=0: DOUT increments by 1, modulo 2^DW (wraps to 0 after all-ones).
- REQ-023 On each accepted word, dir=1: DIN is compared to the expected value, which then increments modulo 2^DW. Each mismatch increments err_cnt, saturating at 255.
- REQ-024 On the accepted word numbered BURST:
  - RDY_O=0 in the following cycle;
  - state goes to DONE;
  - DOUT keeps its final value.
- REQ-025 A RDY_I level held high SHALL count as exactly one word.
- REQ-026 RDY_I edges in IDLE or DONE SHALL be ignored.
- REQ-027 In IDLE or DONE, RDY_O SHALL be cleared on a cycle with clk_en=1.
- REQ-028 busy SHALL be 1 exactly in XFER.
- REQ-029 FCS_N=0 in the same cycle as an RDY_I edge: the register access wins and the edge is dropped.

Reset
- REQ-030 When rst=1, the block SHALL enter IDLE with RDY_O=0, DOUT=0, err_cnt=0, word counter=0, rdy_d=0 and dir=0.
- REQ-031 rst SHALL override every other input, including mid-transfer.

Configuration
- REQ-032 Macro DMA_DEV_CHECK_EN, when defined, SHALL enable the DIN comparison and err_cnt counting.
- REQ-033 Without DMA_DEV_CHECK_EN:
  - DIN is ignored;
  - err_cnt is held at 0;
  - memory-to-device transfers still count words and complete.

Structure
- REQ-034 A shared package dma_pkg SHALL hold the state enum, the status bit positions and the dir bit index (9).
- REQ-035 One sub-module, dma_edge_det, SHALL provide the RDY_I register and the rising-edge pulse.

Verification
- REQ-036 Defaults, dir=0:
  - stimulus: command write DIN=0, then 16 RDY_I pulses;
  - response: DOUT steps 'h200 to 'h210, RDY_O falls after pulse 16, status reads 'b10.
- REQ-037 dir=1 with DMA_DEV_CHECK_EN:
  - stimulus: command DIN='h200, then words 'h200..'h20F with 'h205 replaced by 'h0;
  - response: err_cnt=1, DONE.
- REQ-038 Abort:
  - stimulus: a command write after 5 words;
  - response: counter restarts, DOUT='h200, RDY_O=1, then 16 more words to DONE.
- REQ-039 Held strobe:
  - stimulus: RDY_I held high for 10 cycles;
  - response: exactly 1 word counted.
- REQ-040 Reset mid-transfer:
  - stimulus: rst=1 at word 8;
  - response: next cycle RDY_O=0, busy=0, DOUT=0; following RDY_I edges ignored.
- REQ-041 Wrap-around:
  - stimulus: DW=8, SEED='hFE, BURST=4, dir=0;
  - response: DOUT sequence 'hFE, 'hFF, 'h00, 'h01, 'h02.
